// File: rtl/button_conditioner.sv
// Push-button front end: per-bit synchronizer, sampled saturating-count debouncer
// and rising-edge detector producing one clean pulse per debounced press.
module button_conditioner #(
    parameter int WIDTH          = 4,
    parameter int SAMPLE_CNT_MAX = 62500,
    parameter int PULSE_CNT_MAX  = 200,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_buttons_raw,
    output logic [WIDTH-1:0] o_buttons_level,
    output logic [WIDTH-1:0] o_buttons_pulse
);

    localparam int SCW = $clog2(SAMPLE_CNT_MAX);
    localparam int PCW = $clog2(PULSE_CNT_MAX + 1);

    localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(SAMPLE_CNT_MAX - 1);
    localparam logic [PCW-1:0] PULSE_SAT   = PCW'(PULSE_CNT_MAX);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [SCW-1:0]   r_sample_cnt;
    logic [PCW-1:0]   r_cnt [WIDTH];
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_level_d;
    logic [WIDTH-1:0] r_pulse;

    logic [WIDTH-1:0] w_sync;
    logic             w_tick;
    logic [WIDTH-1:0] w_sat;

    // Plain flop chain: the raw inputs are asynchronous to i_clk.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= i_buttons_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Shared sample tick; phase is fixed relative to reset release.
    assign w_tick = (r_sample_cnt == SAMPLE_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sample_cnt <= '0;
        end else if (w_tick) begin
            r_sample_cnt <= '0;
        end else begin
            r_sample_cnt <= r_sample_cnt + SCW'(1);
        end
    end

    // A single low sample restarts the count, so bounces never accumulate.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (i_rst) begin
                r_cnt[i] <= '0;
            end else if (w_tick) begin
                if (!w_sync[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] != PULSE_SAT) begin
                    r_cnt[i] <= r_cnt[i] + PCW'(1);
                end
            end
        end
    end

    always_comb begin
        w_sat = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_sat[i] = (r_cnt[i] == PULSE_SAT);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_level   <= '0;
            r_level_d <= '0;
            r_pulse   <= '0;
        end else begin
            r_level   <= w_sat;
            r_level_d <= r_level;
            r_pulse   <= r_level & ~r_level_d;
        end
    end

    assign o_buttons_level = r_level;
    assign o_buttons_pulse = r_pulse;

endmodule
